// File: rtl/fifo_interface_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_interface_if
// Description : Ready/enable/data handshake bundle for a FIFO. Carries a
//               write side (in_*) and a read side (out_*).
//               master : producer + consumer view (drives in_enable, in_data,
//                        out_ready; observes in_ready, out_enable, out_data)
//               slave  : FIFO view (the mirror of master)
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_interface_if #(
  parameter int num_bits = 16
);
  logic                in_ready;
  logic                in_enable;
  logic [num_bits-1:0] in_data;
  logic                out_ready;
  logic                out_enable;
  logic [num_bits-1:0] out_data;

  modport master (
    input  in_ready,
    output in_enable,
    output in_data,
    output out_ready,
    input  out_enable,
    input  out_data
  );

  modport slave (
    output in_ready,
    input  in_enable,
    input  in_data,
    input  out_ready,
    output out_enable,
    output out_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_interface.sv
`default_nettype none
// ============================================================================
// Module      : fifo_interface
// Description : Single-clock first-word-fall-through FIFO with a fill-level
//               output. Depth is 2**log_depth words.
//   clk    : rising-edge clock for all state
//   reset  : asynchronous, active-low reset (pointers and count only)
//   bus    : fifo_interface_if.slave handshake (in_* write, out_* read)
//   count  : number of stored words, 0..depth
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_interface #(
  parameter int num_bits  = 16,
  parameter int log_depth = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  fifo_interface_if.slave     bus,
  output logic [log_depth:0]  count
);

  localparam int                 c_depth = 1 << log_depth;
  localparam logic [log_depth:0] c_full  = {1'b1, {log_depth{1'b0}}};

  logic [num_bits-1:0]  r_mem [c_depth];
  logic [log_depth-1:0] r_wr_ptr;
  logic [log_depth-1:0] r_rd_ptr;
  logic [log_depth:0]   r_count;
  logic                 r_in_ready;

  logic                 w_write;
  logic                 w_read;
  logic                 w_out_enable;
  logic [log_depth:0]   w_count_next;

  assign w_out_enable = (r_count != '0);
  assign w_write      = r_in_ready & bus.in_enable;
  assign w_read       = w_out_enable & bus.out_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_read) begin
      w_count_next = r_count + 1'b1;
    end else if (w_read && !w_write) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // in_ready is registered from the next count so that it is low throughout
  // reset, rises on the first edge after release, and a read while full only
  // re-opens the write side on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != c_full);
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_enable = w_out_enable;
  assign bus.out_data   = r_mem[r_rd_ptr];
  assign count          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_interface
// Description : Self-checking bench for fifo_interface. A reference model
//               keeps the FIFO contents as a queue of expected words; a
//               monitor pops and compares whenever the DUT hands a word out.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_interface;

  localparam int NB    = 16;
  localparam int LD    = 4;
  localparam int DEPTH = 1 << LD;

  logic          clk = 1'b0;
  logic          reset;
  logic [LD:0]   count;

  fifo_interface_if #(.num_bits(NB)) bus ();

  fifo_interface #(.num_bits(NB), .log_depth(LD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model: contents as a queue ----------------
  logic [NB-1:0] exp_q[$];
  int            m_count = 0;
  bit            m_armed = 1'b0;   // producer side opens one edge after reset release
  bit            m_wr, m_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_count = 0;
      m_armed = 1'b0;
    end else begin
      m_wr = m_armed && (m_count != DEPTH) && (bus.in_enable === 1'b1);
      m_rd = (m_count != 0) && (bus.out_ready === 1'b1);
      if (m_rd) m_count--;
      if (m_wr) begin
        exp_q.push_back(bus.in_data);
        m_count++;
      end
      m_armed = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic [NB-1:0] exp_word;
  int            n_recv = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("out_enable", {31'd0, bus.out_enable}, {31'd0, m_count != 0});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_armed && (m_count != DEPTH)});
      check("count", 32'(count), 32'(m_count));
      if (bus.out_enable === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("pop_with_empty_scoreboard");
        end else begin
          exp_word = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(exp_word));
          n_recv++;
        end
      end
    end
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [NB-1:0] d);
    bus.in_enable = 1'b1;
    bus.in_data   = d;
    step();
    bus.in_enable = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_enable !== 1'b1) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) fail_now("drain_timeout");
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  int  idx;
  int  cyc;
  bit  acc;

  initial begin
    // Reset held for 100 ns with a producer already pushing.
    reset         = 1'b0;
    bus.in_enable = 1'b1;
    bus.in_data   = 16'h5A5A;
    bus.out_ready = 1'b0;
    #50;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_enable", {31'd0, bus.out_enable}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    #50;
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.in_enable = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_count", 32'(count), 32'd0);
    step();

    // Order and latency.
    bus.in_enable = 1'b1; bus.in_data = 16'h0080; step();
    bus.in_data   = 16'h0000; step();
    bus.in_data   = 16'h1234; step();
    bus.in_enable = 1'b0;
    @(negedge clk);
    check("order_count", 32'(count), 32'd3);
    check("order_head", 32'(bus.out_data), 32'h0080);
    step();
    bus.out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    check("order_empty_after_3", {31'd0, bus.out_enable}, 32'd0);
    step();
    bus.out_ready = 1'b0;

    // Full: 17 writes, the last must be dropped.
    bus.in_enable = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.in_data = NB'($urandom);
      step();
    end
    bus.in_enable = 1'b0;
    @(negedge clk);
    check("full_count", 32'(count), 32'd16);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("full_read_count", 32'(count), 32'd15);
    check("full_read_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    drain();

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) write_word(NB'($urandom));
    @(negedge clk);
    check("simul_pre_count", 32'(count), 32'd5);
    step();
    bus.in_enable = 1'b1;
    bus.in_data   = NB'($urandom);
    bus.out_ready = 1'b1;
    step();
    bus.in_enable = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("simul_count", 32'(count), 32'd5);
    step();
    drain();

    // Wrap-around stream, consumer stalls ~30% of cycles.
    idx = 0;
    cyc = 0;
    while (idx < 512 && cyc < 5000) begin
      bus.in_enable = 1'b1;
      bus.in_data   = NB'(idx);
      bus.out_ready = ($urandom_range(0, 99) >= 30);
      @(negedge clk);
      acc = bus.in_ready;
      if (count > 16) fail_now("stream_count_over_depth");
      step();
      if (acc) idx++;
      cyc++;
    end
    bus.in_enable = 1'b0;
    if (idx < 512) fail_now("stream_timeout");
    drain();

    // Reset mid-stream at count 7.
    for (int i = 0; i < 7; i++) write_word(NB'($urandom));
    @(negedge clk);
    check("mid_pre_count", 32'(count), 32'd7);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_enable", {31'd0, bus.out_enable}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    reset = 1'b1;
    step();
    write_word(16'hBEEF);
    @(negedge clk);
    check("mid_first_valid", {31'd0, bus.out_enable}, 32'd1);
    check("mid_first_word", 32'(bus.out_data), 32'hBEEF);
    step();
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    if (n_recv == 0) fail_now("nothing_received");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
